// File: rtl/float_to_int_seq.sv
// -----------------------------------------------------------------------------
// float_to_int_seq
//
// Multi-cycle float-to-integer converter for the FPU result side. The operand's
// mantissa is loaded into an {int, frac, sticky} accumulator. An iterative
// shifter then moves it one bit per cycle until the binary point lines up with
// the integer field. Finally the value is rounded in the shared round-mode
// encoding and range-checked against the signed or unsigned target.
//
// Ports:
//   clk         clock
//   rst         asynchronous, active-high reset
//   in_valid    operand valid
//   in_ready    converter idle and able to accept an operand
//   op          float operand {sign, exp, frac}
//   round_mode  shared rounding-mode encoding
//   is_signed   1: signed integer result, 0: unsigned integer result
//   out_valid   result valid (held until out_ready)
//   out_ready   consumer accepts result
//   result      converted integer
//   exception   shared 5-bit exception vector (only invalid/inexact used)
// -----------------------------------------------------------------------------

`ifndef FP_ROUND_TONEAREST
`define FP_ROUND_TONEAREST 2'b00
`endif
`ifndef FP_ROUND_UPWARD
`define FP_ROUND_UPWARD 2'b01
`endif
`ifndef FP_ROUND_DOWNWARD
`define FP_ROUND_DOWNWARD 2'b10
`endif
`ifndef FP_ROUND_TOWARDZERO
`define FP_ROUND_TOWARDZERO 2'b11
`endif
`ifndef FP_INVALID
`define FP_INVALID 4
`endif
`ifndef FP_INEXACT
`define FP_INEXACT 0
`endif

module float_to_int_seq #(
    parameter int exp_width  = 8,
    parameter int frac_width = 23,
    parameter int int_width  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [exp_width+frac_width:0]   op,
    input  logic [1:0]                      round_mode,
    input  logic                            is_signed,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [int_width-1:0]            result,
    output logic [4:0]                      exception
);

    localparam int ACC_W   = int_width + frac_width + 1;
    localparam int BIAS    = 2 ** (exp_width - 1) - 1;
    // Beyond this many right shifts every mantissa bit already sits in sticky.
    localparam int MAX_RSH = frac_width + 2;
    localparam int CNT_W   = $clog2(int_width + frac_width + 3);

    // Rounded-magnitude limits for the signed range check.
    localparam logic [int_width:0] SMAX_POS = {2'b00, {(int_width-1){1'b1}}};
    localparam logic [int_width:0] SMAX_NEG = {2'b01, {(int_width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t state, state_nxt;

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             shift_left;
    logic             sign_q;
    logic             nan_q;
    logic             force_inv_q;
    logic [1:0]       mode_q;
    logic             signed_q;

    // ---------------------------------------------------------------- decode
    logic                  op_sign;
    logic [exp_width-1:0]  op_exp;
    logic [frac_width-1:0] op_frac;
    logic [exp_width-1:0]  exp_eff;
    int                    e_int;
    int                    n_int;
    logic                  op_nan;
    logic                  op_special;
    logic [ACC_W-1:0]      acc_load;
    logic                  accept;

    assign {op_sign, op_exp, op_frac} = op;
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        exp_eff    = (op_exp == '0) ? exp_width'(1) : op_exp;
        e_int      = int'(exp_eff) - BIAS;
        op_nan     = (&op_exp) & (|op_frac);
        // Inf, NaN and anything too large for the integer field skip shifting.
        op_special = (&op_exp) | (e_int >= int_width);
        n_int      = 0;
        if (e_int > 0) begin
            n_int = e_int;
        end else if (e_int < 0) begin
            n_int = (-e_int > MAX_RSH) ? MAX_RSH : -e_int;
        end
        acc_load = {{(int_width-1){1'b0}}, |op_exp, op_frac, 1'b0};
    end

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) state_nxt = (op_special || n_int == 0) ? ROUND : SHIFT;
            SHIFT: if (cnt == CNT_W'(1)) state_nxt = ROUND;
            ROUND: state_nxt = DONE;
            DONE:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------- rounding
    logic [int_width-1:0] int_part;
    logic                 guard;
    logic                 rest;
    logic                 inc;
    logic [int_width:0]   mag;
    logic                 range_inv;
    logic                 invalid;
    logic                 inexact;
    logic                 sat_neg;
    logic [int_width-1:0] rnd_result;
    logic [4:0]           rnd_exc;

    always_comb begin
        int_part = acc[ACC_W-1 -: int_width];
        guard    = acc[frac_width];
        // Lower fraction bits and the sticky bit together.
        rest     = |acc[frac_width-1:0];

        case (mode_q)
            `FP_ROUND_TONEAREST: inc = guard & (rest | acc[frac_width+1]);
            `FP_ROUND_UPWARD:    inc = ~sign_q & (guard | rest);
            `FP_ROUND_DOWNWARD:  inc = sign_q & (guard | rest);
            default:             inc = 1'b0;
        endcase

        // One extra bit so a carry out of the integer field is visible.
        mag = {1'b0, int_part} + {{int_width{1'b0}}, inc};

        if (signed_q) begin
            range_inv = sign_q ? (mag > SMAX_NEG) : (mag > SMAX_POS);
        end else begin
            range_inv = (sign_q & (mag != '0)) | mag[int_width];
        end

        invalid = force_inv_q | range_inv;
        inexact = (guard | rest) & ~invalid;
        // NaN saturates like a positive overflow.
        sat_neg = sign_q & ~nan_q;

        if (invalid) begin
            if (signed_q) begin
                rnd_result = sat_neg ? {1'b1, {(int_width-1){1'b0}}}
                                     : {1'b0, {(int_width-1){1'b1}}};
            end else begin
                rnd_result = sat_neg ? '0 : '1;
            end
        end else begin
            rnd_result = sign_q ? -mag[int_width-1:0] : mag[int_width-1:0];
        end

        rnd_exc              = '0;
        rnd_exc[`FP_INVALID] = invalid;
        rnd_exc[`FP_INEXACT] = inexact;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            cnt         <= '0;
            shift_left  <= 1'b0;
            sign_q      <= 1'b0;
            nan_q       <= 1'b0;
            force_inv_q <= 1'b0;
            mode_q      <= '0;
            signed_q    <= 1'b0;
            result      <= '0;
            exception   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc         <= acc_load;
                        cnt         <= CNT_W'(n_int);
                        shift_left  <= (e_int > 0);
                        sign_q      <= op_sign;
                        nan_q       <= op_nan;
                        force_inv_q <= op_special;
                        mode_q      <= round_mode;
                        signed_q    <= is_signed;
                    end
                end
                SHIFT: begin
                    if (shift_left) begin
                        acc <= {acc[ACC_W-2:0], 1'b0};
                    end else begin
                        // The bit leaving the fraction LSB folds into sticky.
                        acc <= {1'b0, acc[ACC_W-1:2], acc[1] | acc[0]};
                    end
                    cnt <= cnt - CNT_W'(1);
                end
                ROUND: begin
                    result    <= rnd_result;
                    exception <= rnd_exc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int_seq.sv
// -----------------------------------------------------------------------------
// Testbench for float_to_int_seq (binary32 -> 32-bit integer). Directed vectors
// with known answers, then randomized operands compared against a real-valued
// reference model of the conversion and its latency.
// -----------------------------------------------------------------------------

`ifndef FP_ROUND_TONEAREST
`define FP_ROUND_TONEAREST 2'b00
`endif
`ifndef FP_ROUND_UPWARD
`define FP_ROUND_UPWARD 2'b01
`endif
`ifndef FP_ROUND_DOWNWARD
`define FP_ROUND_DOWNWARD 2'b10
`endif
`ifndef FP_ROUND_TOWARDZERO
`define FP_ROUND_TOWARDZERO 2'b11
`endif
`ifndef FP_INVALID
`define FP_INVALID 4
`endif
`ifndef FP_INEXACT
`define FP_INEXACT 0
`endif

module tb_float_to_int_seq;

    localparam logic [1:0] RNE = `FP_ROUND_TONEAREST;
    localparam logic [1:0] RUP = `FP_ROUND_UPWARD;
    localparam logic [1:0] RDN = `FP_ROUND_DOWNWARD;
    localparam logic [1:0] RTZ = `FP_ROUND_TOWARDZERO;
    localparam logic [4:0] EX_INV = 5'(1) << `FP_INVALID;
    localparam logic [4:0] EX_INX = 5'(1) << `FP_INEXACT;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op;
    logic [1:0]  round_mode;
    logic        is_signed;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  exception;

    int n_checks = 0;
    int n_fail   = 0;

    float_to_int_seq #(.exp_width(8), .frac_width(23), .int_width(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .round_mode (round_mode),
        .is_signed  (is_signed),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .exception  (exception)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact real value, then rounding and range rules on numbers.
    task automatic model(input logic [31:0] f, input logic [1:0] rm, input logic sg,
                         output logic [31:0] r, output logic [4:0] x, output int lat);
        logic neg, nan, inf, odd, inc, inv;
        int   ex, e;
        real  mag, ip, fr, m;
        neg = f[31];
        ex  = int'(f[30:23]);
        nan = (ex == 255) && (f[22:0] != 0);
        inf = (ex == 255) && (f[22:0] == 0);
        e   = ((ex == 0) ? 1 : ex) - 127;
        mag = ((ex != 0) ? 1.0 : 0.0) + real'(int'(f[22:0])) / 8388608.0;
        mag = mag * (2.0 ** e);
        ip  = $floor(mag);
        fr  = mag - ip;
        odd = (ip < 1.0e12) ? ((longint'(ip) % 2) == 1) : 1'b0;
        case (rm)
            RNE:     inc = (fr > 0.5) || ((fr == 0.5) && odd);
            RUP:     inc = !neg && (fr > 0.0);
            RDN:     inc = neg && (fr > 0.0);
            default: inc = 1'b0;
        endcase
        m = ip + (inc ? 1.0 : 0.0);
        if (nan || inf)  inv = 1'b1;
        else if (sg)     inv = neg ? (m > 2147483648.0) : (m > 2147483647.0);
        else             inv = (neg && (m != 0.0)) || (m >= 4294967296.0);
        x = '0;
        if (inv) begin
            x = EX_INV;
            if (nan)     r = sg ? 32'h7FFF_FFFF : 32'hFFFF_FFFF;
            else if (sg) r = neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
            else         r = neg ? 32'h0 : 32'hFFFF_FFFF;
        end else begin
            longint mi;
            mi = longint'(m);
            if (neg) mi = -mi;
            r = mi[31:0];
            if (fr > 0.0) x = EX_INX;
        end
        if (ex == 255 || e >= 32) lat = 1;
        else if (e > 0)           lat = e + 1;
        else if (e < 0)           lat = ((-e > 25) ? 25 : -e) + 1;
        else                      lat = 1;
    endtask

    // One conversion; bp = cycles out_ready stays low once the result is up.
    task automatic run(input logic [31:0] f, input logic [1:0] rm, input logic sg,
                       input int bp, input string tag,
                       input logic use_const, input logic [31:0] c_res, input logic [4:0] c_exc);
        logic [31:0] m_res;
        logic [4:0]  m_exc;
        int          m_lat;
        int          lat;
        logic [31:0] held_res;
        logic [4:0]  held_exc;
        model(f, rm, sg, m_res, m_exc, m_lat);
        out_ready  = (bp == 0);
        op         = f;
        round_mode = rm;
        is_signed  = sg;
        in_valid   = 1'b1;
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(m_lat));
        if (lat >= 100) return;
        check({tag, ".result"}, 64'(result), 64'(m_res));
        check({tag, ".exception"}, 64'(exception), 64'(m_exc));
        if (use_const) begin
            check({tag, ".result_known"}, 64'(result), 64'(c_res));
            check({tag, ".exception_known"}, 64'(exception), 64'(c_exc));
        end
        held_res = result;
        held_exc = exception;
        for (int i = 0; i < bp; i++) begin
            in_valid = 1'b1;
            op       = $urandom;
            @(posedge clk); #1;
            check({tag, ".bp_out_valid"}, 64'(out_valid), 64'd1);
            check({tag, ".bp_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, ".bp_result"}, 64'(result), 64'(held_res));
            check({tag, ".bp_exception"}, 64'(exception), 64'(held_exc));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".handoff_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".handoff_in_ready"}, 64'(in_ready), 64'd1);
    endtask

    typedef struct {
        logic [31:0] f;
        logic [1:0]  rm;
        logic        sg;
        logic [31:0] r;
        logic [4:0]  x;
    } vec_t;

    vec_t vecs[15] = '{
        '{32'h3FC0_0000, RNE, 1'b1, 32'h0000_0002, EX_INX},
        '{32'h4020_0000, RNE, 1'b1, 32'h0000_0002, EX_INX},
        '{32'h4020_0000, RUP, 1'b1, 32'h0000_0003, EX_INX},
        '{32'hC020_0000, RDN, 1'b1, 32'hFFFF_FFFD, EX_INX},
        '{32'hC020_0000, RTZ, 1'b1, 32'hFFFF_FFFE, EX_INX},
        '{32'hCF00_0000, RNE, 1'b1, 32'h8000_0000, 5'h0},
        '{32'h4F00_0000, RNE, 1'b1, 32'h7FFF_FFFF, EX_INV},
        '{32'h7FC0_0000, RNE, 1'b1, 32'h7FFF_FFFF, EX_INV},
        '{32'hBF80_0000, RNE, 1'b0, 32'h0000_0000, EX_INV},
        '{32'hBE80_0000, RNE, 1'b0, 32'h0000_0000, EX_INX},
        '{32'h4F80_0000, RNE, 1'b0, 32'hFFFF_FFFF, EX_INV},
        '{32'h0000_0000, RNE, 1'b1, 32'h0000_0000, 5'h0},
        '{32'h8000_0000, RUP, 1'b0, 32'h0000_0000, 5'h0},
        '{32'h7F80_0000, RNE, 1'b0, 32'hFFFF_FFFF, EX_INV},
        '{32'hFF80_0000, RNE, 1'b1, 32'h8000_0000, EX_INV}
    };

    initial begin
        logic [31:0] f;
        int          sel;
        int          bp;
        int          lat;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        op         = '0;
        round_mode = RNE;
        is_signed  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset.in_ready", 64'(in_ready), 64'd1);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.result", 64'(result), 64'd0);
        check("reset.exception", 64'(exception), 64'd0);

        foreach (vecs[i])
            run(vecs[i].f, vecs[i].rm, vecs[i].sg, 0, $sformatf("vec%0d", i),
                1'b1, vecs[i].r, vecs[i].x);

        // Backpressure: result held five cycles, new operands ignored meanwhile.
        run(32'h3FC0_0000, RNE, 1'b1, 5, "bp", 1'b1, 32'h2, EX_INX);
        run(32'h4020_0000, RUP, 1'b1, 0, "after_bp", 1'b1, 32'h3, EX_INX);

        // Reset in the middle of a long left-shift sequence.
        op = 32'h4E00_0000; round_mode = RNE; is_signed = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst.out_valid", 64'(out_valid), 64'd0);
        check("midrst.result", 64'(result), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        check("midrst.in_ready", 64'(in_ready), 64'd1);
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (out_valid) break;
        end
        check("midrst.no_stale_output", 64'(out_valid), 64'd0);
        run(32'h3F80_0000, RNE, 1'b1, 0, "after_rst", 1'b1, 32'h1, 5'h0);

        // Randomized operands, biased toward the interesting exponent window.
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            f   = $urandom;
            if (sel < 7)       f[30:23] = 8'($urandom_range(100, 160));
            else if (sel == 7) f[30:23] = 8'h00;
            else if (sel == 8) f[30:23] = 8'hFF;
            if ($urandom_range(0, 3) == 0) f[15:0] = '0;
            bp = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            run(f, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), bp,
                $sformatf("rand%0d_%08h", i, f), 1'b0, 32'h0, 5'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
